seg_decoder: RTL and testbench



---
 rtl/seg_decoder_if.sv | 37 +++
 rtl/seg_decoder.sv | 162 ++++++++++++++++
 tb/tb_seg_decoder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_decoder_if
//   Bundles the segment bus seen by the digit checker and its decoded results.
//
//   seg_in       [SEG_SIZE-1:0] raw segment lines (bit 7 = decimal point)
//   digit        [3:0]          last accepted BCD digit
//   digit_valid                 one-cycle pulse on each accepted digit
//   invalid_pat                 one-cycle pulse on an accepted non-digit pattern
//   seq_err                     one-cycle pulse on a broken count sequence
//   locked                      high while the count sequence is being tracked
//   digit_count  [CNT_SIZE-1:0] number of accepted digits, wraps on overflow
//
//   master: drives seg_in, observes results (display side / testbench)
//   slave:  samples seg_in, produces results (seg_decoder)
// ---------------------------------------------------------------------------
interface seg_decoder_if #(
    parameter int SEG_SIZE = 8,
    parameter int CNT_SIZE = 16
);
    logic [SEG_SIZE-1:0] seg_in;
    logic [3:0]          digit;
    logic                digit_valid;
    logic                invalid_pat;
    logic                seq_err;
    logic                locked;
    logic [CNT_SIZE-1:0] digit_count;

    modport master (
        output seg_in,
        input  digit, digit_valid, invalid_pat, seq_err, locked, digit_count
    );

    modport slave (
        input  seg_in,
        output digit, digit_valid, invalid_pat, seq_err, locked, digit_count
    );
endinterface

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
//   Receive-side monitor for a common-cathode 7-segment digit bus. Samples the
//   segment lines through a two-flop synchronizer, waits for a pattern to stay
//   put for STABLE_CYCLES samples, decodes it to BCD and checks that accepted
//   digits follow the 0..9 wrap-around count.
//
//   hwclk   system clock, all logic on posedge
//   rst     synchronous, active-high reset
//   bus     seg_decoder_if.slave (seg_in in; digit, digit_valid, invalid_pat,
//           seq_err, locked, digit_count out)
// ---------------------------------------------------------------------------
module seg_decoder #(
    parameter int SEG_SIZE      = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_SIZE      = 16
) (
    input logic          hwclk,
    input logic          rst,
    seg_decoder_if.slave bus
);

    localparam int            CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [6:0]    BLANK      = 7'h00;

    typedef enum logic [1:0] {IDLE, FIRST, LOCKED} state_t;

    logic [6:0]          sync1, sync2;
    logic [6:0]          cand, cand_next;
    logic [6:0]          last_pat;
    logic [CW-1:0]       cnt, cnt_next;
    logic                accept;
    logic                dec_valid;
    logic [3:0]          dec_digit;

    state_t              state;
    logic [3:0]          ref_digit;
    logic [3:0]          digit_r;
    logic                digit_valid_r, invalid_pat_r, seq_err_r, locked_r;
    logic [CNT_SIZE-1:0] count_r;

    // The decimal point never takes part in matching or decoding.
    logic unused_dp;
    assign unused_dp = ^bus.seg_in[SEG_SIZE-1:7];

    // Segment pattern (a = bit 6 .. g = bit 0) to {valid, digit}.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h7E:   decode = {1'b1, 4'd0};
            7'h30:   decode = {1'b1, 4'd1};
            7'h6D:   decode = {1'b1, 4'd2};
            7'h79:   decode = {1'b1, 4'd3};
            7'h33:   decode = {1'b1, 4'd4};
            7'h5B:   decode = {1'b1, 4'd5};
            7'h5F:   decode = {1'b1, 4'd6};
            7'h70:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h7B:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [3:0] succ(input logic [3:0] d);
        succ = (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Stability tracking. Acceptance fires on the sample that brings the count
    // to STABLE_CYCLES, so flags are registered on that same edge. Comparing
    // against the last accepted pattern makes a held pattern fire only once and
    // lets a short glitch back to that pattern pass silently.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cand_next = cand;
        cnt_next  = cnt;
        if (sync2 != cand) begin
            cand_next = sync2;
            cnt_next  = CW'(1);
        end else if (cnt != STABLE_MAX) begin
            cnt_next = cnt + 1'b1;
        end
        accept = (cnt_next == STABLE_MAX) && (cand_next != last_pat);
        {dec_valid, dec_digit} = decode(cand_next);
    end

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every register sees the pre-edge value of every other register.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            sync1         <= '0;
            sync2         <= '0;
            cand          <= '0;
            cnt           <= '0;
            last_pat      <= BLANK;
            state         <= IDLE;
            ref_digit     <= '0;
            digit_r       <= '0;
            digit_valid_r <= 1'b0;
            invalid_pat_r <= 1'b0;
            seq_err_r     <= 1'b0;
            locked_r      <= 1'b0;
            count_r       <= '0;
        end else begin
            sync1         <= bus.seg_in[6:0];
            sync2         <= sync1;
            cand          <= cand_next;
            cnt           <= cnt_next;
            digit_valid_r <= 1'b0;
            invalid_pat_r <= 1'b0;
            seq_err_r     <= 1'b0;

            if (accept) begin
                last_pat <= cand_next;
                // A blank only updates the last-accepted pattern.
                if (cand_next != BLANK) begin
                    if (!dec_valid) begin
                        invalid_pat_r <= 1'b1;
                        state         <= IDLE;
                        locked_r      <= 1'b0;
                    end else begin
                        digit_r       <= dec_digit;
                        digit_valid_r <= 1'b1;
                        count_r       <= count_r + 1'b1;
                        ref_digit     <= dec_digit;
                        case (state)
                            IDLE: begin
                                state    <= FIRST;
                                locked_r <= 1'b0;
                            end
                            FIRST: begin
                                if (dec_digit == succ(ref_digit)) begin
                                    state    <= LOCKED;
                                    locked_r <= 1'b1;
                                end
                            end
                            LOCKED: begin
                                if (dec_digit != succ(ref_digit)) begin
                                    seq_err_r <= 1'b1;
                                    state     <= FIRST;
                                    locked_r  <= 1'b0;
                                end
                            end
                            default: begin
                                state    <= IDLE;
                                locked_r <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign bus.digit       = digit_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.invalid_pat = invalid_pat_r;
    assign bus.seq_err     = seq_err_r;
    assign bus.locked      = locked_r;
    assign bus.digit_count = count_r;

endmodule

// File: tb/tb_seg_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_decoder
//   Self-checking bench for seg_decoder. A behavioural model predicts every
//   output on every cycle from the input history: a pattern held for
//   STABLE_CYCLES consecutive clock edges starting at edge t is accepted at
//   edge t+STABLE_CYCLES+1 unless it equals the previously accepted pattern.
//   CNT_SIZE is reduced so the digit counter wrap can be reached quickly.
// ---------------------------------------------------------------------------
module tb_seg_decoder;

    localparam int SEG_SIZE = 8;
    localparam int STABLE   = 4;
    localparam int CNT_SIZE = 4;

    logic hwclk = 1'b0;
    logic rst   = 1'b1;
    always #5 hwclk = ~hwclk;

    seg_decoder_if #(.SEG_SIZE(SEG_SIZE), .CNT_SIZE(CNT_SIZE)) bus ();

    seg_decoder #(
        .SEG_SIZE     (SEG_SIZE),
        .STABLE_CYCLES(STABLE),
        .CNT_SIZE     (CNT_SIZE)
    ) dut (
        .hwclk(hwclk),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Model state
    logic [6:0]          run_pat;
    int                  run_len;
    logic [6:0]          last_sched;
    int                  pend_cyc [$];
    logic [6:0]          pend_pat [$];
    logic [3:0]          m_digit;
    logic [CNT_SIZE-1:0] m_count;
    logic                m_locked, m_tracking;
    int                  m_ref;
    logic                m_dv, m_inv, m_se;

    // Observed pulses of the latest tick and per-scenario tallies
    logic o_dv, o_inv, o_se;
    int   n_dv, n_inv, n_se;

    function automatic int decode_digit(input logic [6:0] p);
        decode_digit = -1;
        for (int i = 0; i < 10; i++)
            if (seg_tbl[i] == p) decode_digit = i;
    endfunction

    task automatic model_accept(input logic [6:0] p);
        int d;
        if (p == 7'h00) return;
        d = decode_digit(p);
        if (d < 0) begin
            m_inv      = 1'b1;
            m_tracking = 1'b0;
            m_locked   = 1'b0;
        end else begin
            m_dv    = 1'b1;
            m_digit = 4'(d);
            m_count = m_count + 1'b1;
            if (!m_tracking) begin
                m_tracking = 1'b1;
                m_locked   = 1'b0;
            end else if (d == (m_ref + 1) % 10) begin
                m_locked = 1'b1;
            end else begin
                m_se     = m_locked;
                m_locked = 1'b0;
            end
            m_ref = d;
        end
    endtask

    // One clock edge: advance the model, then compare every output.
    task automatic tick();
        @(posedge hwclk);
        cyc++;
        m_dv  = 1'b0;
        m_inv = 1'b0;
        m_se  = 1'b0;
        if (rst) begin
            m_digit    = '0;
            m_count    = '0;
            m_locked   = 1'b0;
            m_tracking = 1'b0;
            m_ref      = 0;
            last_sched = 7'h00;
            pend_cyc.delete();
            pend_pat.delete();
            run_pat    = bus.seg_in[6:0];
            run_len    = 0;
        end else begin
            if (bus.seg_in[6:0] == run_pat) begin
                run_len++;
            end else begin
                run_pat = bus.seg_in[6:0];
                run_len = 1;
            end
            if (run_len == STABLE && run_pat != last_sched) begin
                pend_cyc.push_back(cyc + 2);
                pend_pat.push_back(run_pat);
                last_sched = run_pat;
            end
            if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
                void'(pend_cyc.pop_front());
                model_accept(pend_pat.pop_front());
            end
        end
        #1;
        checks += 6;
        if (bus.digit !== m_digit) begin
            errors++;
            $display("FAIL digit cyc=%0d got=%0d exp=%0d", cyc, bus.digit, m_digit);
        end
        if (bus.digit_valid !== m_dv) begin
            errors++;
            $display("FAIL digit_valid cyc=%0d got=%b exp=%b", cyc, bus.digit_valid, m_dv);
        end
        if (bus.invalid_pat !== m_inv) begin
            errors++;
            $display("FAIL invalid_pat cyc=%0d got=%b exp=%b", cyc, bus.invalid_pat, m_inv);
        end
        if (bus.seq_err !== m_se) begin
            errors++;
            $display("FAIL seq_err cyc=%0d got=%b exp=%b", cyc, bus.seq_err, m_se);
        end
        if (bus.locked !== m_locked) begin
            errors++;
            $display("FAIL locked cyc=%0d got=%b exp=%b", cyc, bus.locked, m_locked);
        end
        if (bus.digit_count !== m_count) begin
            errors++;
            $display("FAIL digit_count cyc=%0d got=%0d exp=%0d", cyc, bus.digit_count, m_count);
        end
        o_dv  = bus.digit_valid;
        o_inv = bus.invalid_pat;
        o_se  = bus.seq_err;
        if (o_dv === 1'b1)  n_dv++;
        if (o_inv === 1'b1) n_inv++;
        if (o_se === 1'b1)  n_se++;
    endtask

    task automatic clear_counts();
        n_dv  = 0;
        n_inv = 0;
        n_se  = 0;
    endtask

    task automatic drive(input logic [7:0] pat, input int hold);
        bus.seg_in = pat;
        repeat (hold) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.seg_in = 8'h00;
        do_reset();
        checks++;
        if ({bus.digit, bus.digit_valid, bus.invalid_pat, bus.seq_err, bus.locked} !== 8'h00
            || bus.digit_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got digit=%0d flags=%b%b%b%b count=%0d exp all 0",
                     bus.digit, bus.digit_valid, bus.invalid_pat, bus.seq_err, bus.locked,
                     bus.digit_count);
        end
    endtask

    task automatic test_first_digit();
        int first_at;
        do_reset();
        clear_counts();
        first_at   = -1;
        bus.seg_in = 8'h7E;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_dv === 1'b1 && first_at < 0) first_at = i;
        end
        checks += 5;
        if (n_dv != 1) begin errors++; $display("FAIL first_pulses got=%0d exp=1", n_dv); end
        if (first_at != STABLE + 1) begin
            errors++; $display("FAIL first_latency got=%0d exp=%0d", first_at, STABLE + 1);
        end
        if (bus.digit !== 4'd0) begin errors++; $display("FAIL first_digit got=%0d exp=0", bus.digit); end
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL first_locked got=%b exp=0", bus.locked); end
        if (n_inv + n_se != 0) begin
            errors++; $display("FAIL first_other_pulses got=%0d exp=0", n_inv + n_se);
        end
    endtask

    task automatic test_count_sequence();
        int idx;
        do_reset();
        clear_counts();
        idx = 0;
        for (int k = 0; k < 11; k++) begin
            bus.seg_in = {1'b0, seg_tbl[k % 10]};
            for (int i = 0; i < 8; i++) begin
                tick();
                if (o_dv === 1'b1) begin
                    checks += 2;
                    if (bus.digit !== 4'(idx % 10)) begin
                        errors++; $display("FAIL seq_digit got=%0d exp=%0d", bus.digit, idx % 10);
                    end
                    if (bus.locked !== (idx >= 1)) begin
                        errors++; $display("FAIL seq_locked pulse=%0d got=%b exp=%b", idx, bus.locked, idx >= 1);
                    end
                    idx++;
                end
            end
        end
        checks += 3;
        if (n_dv != 11) begin errors++; $display("FAIL seq_pulses got=%0d exp=11", n_dv); end
        if (n_se != 0) begin errors++; $display("FAIL seq_errs got=%0d exp=0", n_se); end
        if (bus.digit_count !== CNT_SIZE'(11)) begin
            errors++; $display("FAIL seq_count got=%0d exp=11", bus.digit_count);
        end
    endtask

    task automatic test_seq_break();
        do_reset();
        drive({1'b0, seg_tbl[2]}, 8);
        drive({1'b0, seg_tbl[3]}, 8);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL break_prelock got=%b exp=1", bus.locked); end
        clear_counts();
        bus.seg_in = {1'b0, seg_tbl[5]};
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_dv === 1'b1) begin
                checks += 3;
                if (o_se !== 1'b1) begin errors++; $display("FAIL break_seq_err got=%b exp=1", o_se); end
                if (bus.digit !== 4'd5) begin errors++; $display("FAIL break_digit got=%0d exp=5", bus.digit); end
                if (bus.locked !== 1'b0) begin errors++; $display("FAIL break_locked got=%b exp=0", bus.locked); end
            end
        end
        checks++;
        if (n_dv != 1 || n_se != 1) begin
            errors++; $display("FAIL break_pulses got dv=%0d se=%0d exp 1/1", n_dv, n_se);
        end
        clear_counts();
        drive({1'b0, seg_tbl[6]}, 8);
        checks++;
        if (bus.locked !== 1'b1 || n_se != 0) begin
            errors++; $display("FAIL relock got locked=%b se=%0d exp 1/0", bus.locked, n_se);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        drive(8'h30, 8);
        clear_counts();
        drive(8'h6D, 3);
        drive(8'h30, 8);
        checks += 2;
        if (n_dv + n_inv + n_se != 0) begin
            errors++; $display("FAIL glitch_pulses got=%0d exp=0", n_dv + n_inv + n_se);
        end
        if (bus.digit !== 4'd1) begin errors++; $display("FAIL glitch_digit got=%0d exp=1", bus.digit); end
        clear_counts();
        for (int i = 0; i < 10; i++) drive({i[0], 7'h30}, 1);
        checks++;
        if (n_dv + n_inv + n_se != 0) begin
            errors++; $display("FAIL dp_toggle_pulses got=%0d exp=0", n_dv + n_inv + n_se);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        drive({1'b0, seg_tbl[0]}, 8);
        drive({1'b0, seg_tbl[1]}, 8);
        clear_counts();
        drive(8'h01, 8);
        checks += 2;
        if (n_inv != 1 || n_dv != 0) begin
            errors++; $display("FAIL invalid_pulses got inv=%0d dv=%0d exp 1/0", n_inv, n_dv);
        end
        if (bus.digit !== 4'd1 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL invalid_state got digit=%0d locked=%b exp 1/0", bus.digit, bus.locked);
        end
        clear_counts();
        drive(8'h00, 8);
        checks++;
        if (n_dv + n_inv + n_se != 0) begin
            errors++; $display("FAIL blank_pulses got=%0d exp=0", n_dv + n_inv + n_se);
        end
        clear_counts();
        drive(8'h30, 8);
        checks++;
        if (n_dv != 1 || bus.locked !== 1'b0) begin
            errors++; $display("FAIL after_invalid got dv=%0d locked=%b exp 1/0", n_dv, bus.locked);
        end
        drive(8'h6D, 8);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL after_invalid_lock got=%b exp=1", bus.locked); end
    endtask

    task automatic test_reset_mid();
        int at;
        do_reset();
        drive({1'b0, seg_tbl[0]}, 8);
        drive(8'h33, STABLE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.digit, bus.digit_valid, bus.invalid_pat, bus.seq_err, bus.locked} !== 8'h00
            || bus.digit_count !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got digit=%0d count=%0d exp all 0", bus.digit, bus.digit_count);
        end
        at = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_dv === 1'b1 && at < 0) at = i;
        end
        checks += 2;
        if (at != STABLE + 1) begin
            errors++; $display("FAIL midreset_latency got=%0d exp=%0d", at, STABLE + 1);
        end
        if (bus.digit !== 4'd4) begin errors++; $display("FAIL midreset_digit got=%0d exp=4", bus.digit); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) drive({1'b0, seg_tbl[k % 10]}, 6);
        checks++;
        if (bus.digit_count !== CNT_SIZE'(17 % (1 << CNT_SIZE))) begin
            errors++; $display("FAIL wrap_count got=%0d exp=%0d", bus.digit_count, 17 % (1 << CNT_SIZE));
        end
    endtask

    task automatic test_random();
        int         kind;
        int         prev;
        logic [7:0] p;
        do_reset();
        prev = 0;
        for (int s = 0; s < 200; s++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                prev = (prev + 1) % 10;
                p    = {1'b0, seg_tbl[prev]};
            end else if (kind < 8) begin
                prev = int'($urandom_range(0, 9));
                p    = {1'b0, seg_tbl[prev]};
            end else if (kind == 8) begin
                p = 8'h00;
            end else begin
                p = 8'($urandom);
            end
            p[7] = 1'($urandom_range(0, 1));
            drive(p, int'($urandom_range(1, 9)));
        end
    endtask

    initial begin
        bus.seg_in = 8'h00;
        clear_counts();
        test_reset();
        test_first_digit();
        test_count_sequence();
        test_seq_break();
        test_glitch();
        test_invalid();
        test_reset_mid();
        test_count_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
